// File: rtl/alpaca_bfly_align.sv
// Pairs even/odd FFT sub-transform samples: buffers the first half of each frame,
// then emits (buf[k], odd[k]) through a single skid-free output register; tdata = {re, im}.
module alpaca_bfly_align #(
  parameter int FFT_LEN = 16,
  parameter int WIDTH   = 16,
  parameter int TUSER   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [2*WIDTH-1:0]   s_axis_tdata_i,
  input  logic                 s_axis_tvalid_i,
  input  logic                 s_axis_tlast_i,
  output logic                 s_axis_tready_o,
  output logic [2*WIDTH-1:0]   x1_tdata_o,
  output logic                 x1_tvalid_o,
  output logic                 x1_tlast_o,
  output logic [TUSER-1:0]     x1_tuser_o,
  input  logic                 x1_tready_i,
  output logic [2*WIDTH-1:0]   x2_tdata_o,
  output logic                 x2_tvalid_o,
  output logic                 x2_tlast_o,
  output logic [TUSER-1:0]     x2_tuser_o,
  input  logic                 x2_tready_i,
  output logic                 err_o
);

  localparam int H  = FFT_LEN / 2;
  localparam int IW = $clog2(H);
  localparam logic [IW-1:0] LAST_IDX = IW'(H - 1);

  typedef enum logic {FILL, PAIR} state_t;

  state_t               state_q, state_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [TUSER-1:0]     fc_q, fc_d;
  logic                 out_vld_q, out_vld_d;
  logic [2*WIDTH-1:0]   x1_q, x1_d;
  logic [2*WIDTH-1:0]   x2_q, x2_d;
  logic                 last_q, last_d;
  logic [TUSER-1:0]     user_q, user_d;
  logic                 err_q, err_d;

  logic [2*WIDTH-1:0]   mem_q [H];

  logic out_rdy;
  logic s_rdy;
  logic accept;
  logic is_last;
  logic wr_en;

  always_comb begin
    out_rdy   = x1_tready_i && x2_tready_i;
    s_rdy     = 1'b0;
    if (!rst) begin
      s_rdy = (state_q == FILL) ? 1'b1 : (!out_vld_q || out_rdy);
    end
    accept    = s_axis_tvalid_i && s_rdy;
    is_last   = (idx_q == LAST_IDX);

    state_d   = state_q;
    idx_d     = idx_q;
    fc_d      = fc_q;
    out_vld_d = out_vld_q;
    x1_d      = x1_q;
    x2_d      = x2_q;
    last_d    = last_q;
    user_d    = user_q;
    err_d     = 1'b0;
    wr_en     = 1'b0;

    if (out_rdy) begin
      out_vld_d = 1'b0;
    end

    if (accept) begin
      // Any tlast other than on the final odd beat is a resync: drop the beat, keep fc.
      if (s_axis_tlast_i && !(state_q == PAIR && is_last)) begin
        err_d   = 1'b1;
        state_d = FILL;
        idx_d   = '0;
      end else if (state_q == FILL) begin
        wr_en = 1'b1;
        if (is_last) begin
          state_d = PAIR;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end else begin
        out_vld_d = 1'b1;
        x1_d      = mem_q[idx_q];
        x2_d      = s_axis_tdata_i;
        last_d    = is_last;
        user_d    = fc_q;
        if (is_last) begin
          state_d = FILL;
          idx_d   = '0;
          fc_d    = fc_q + 1'b1;
          err_d   = !s_axis_tlast_i;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= FILL;
      idx_q     <= '0;
      fc_q      <= '0;
      out_vld_q <= 1'b0;
      x1_q      <= '0;
      x2_q      <= '0;
      last_q    <= 1'b0;
      user_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      fc_q      <= fc_d;
      out_vld_q <= out_vld_d;
      x1_q      <= x1_d;
      x2_q      <= x2_d;
      last_q    <= last_d;
      user_q    <= user_d;
      err_q     <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[idx_q] <= s_axis_tdata_i;
    end
  end

  assign s_axis_tready_o = s_rdy;
  assign x1_tdata_o      = x1_q;
  assign x2_tdata_o      = x2_q;
  assign x1_tvalid_o     = out_vld_q;
  assign x2_tvalid_o     = out_vld_q;
  assign x1_tlast_o      = last_q;
  assign x2_tlast_o      = last_q;
  assign x1_tuser_o      = user_q;
  assign x2_tuser_o      = user_q;
  assign err_o           = err_q;

endmodule

// File: doc/alpaca_bfly_align.md
ALPACA_BFLY_ALIGN -- requirements
Module: alpaca_bfly_align

Interface
REQ-001 SHALL have parameter FFT_LEN, default 16, full transform length; power of two, >= 4; half length H = FFT_LEN/2.
REQ-002 SHALL have parameter WIDTH, default 16, bits per re/im component of cx_t.
REQ-003 SHALL have parameter TUSER, default 8, width of output tuser.
REQ-004 clk  input  1  single clock; all logic on posedge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 s_axis  alpaca_axis.SLV  cx_t (2*WIDTH) + tvalid/tready/tlast  input frame of FFT_LEN samples: beats 0..H-1 are the even sub-transform, beats H..FFT_LEN-1 the odd sub-transform.
REQ-007 x1  alpaca_axis.MST  cx_t + tvalid/tlast/tuser  even-half sample k; consumes x1.tready.
REQ-008 x2  alpaca_axis.MST  cx_t + tvalid/tlast/tuser  odd-half sample k, always beat-aligned with x1.
REQ-009 err  output  1  one-cycle pulse on frame-alignment error.

Function
REQ-010 SHALL contain an H-entry buffer of cx_t, written during FILL, read combinationally during PAIR; buffer contents need not be reset.
REQ-011 SHALL use an index counter idx of $clog2(H) bits and a 2-state FSM: FILL, PAIR.
REQ-012 FILL: s_axis.tready = 1; each accepted beat writes buf[idx]; idx increments; beat idx = H-1 moves FSM to PAIR with idx = 0.
REQ-013 PAIR: s_axis.tready = !out_vld || (x1.tready && x2.tready); accepted beat loads output register with x1 = buf[idx], x2 = s_axis.tdata; idx increments.
REQ-014 PAIR beat idx = H-1 SHALL return FSM to FILL, idx = 0, and increment frame counter fc (TUSER bits, wraps 2^TUSER-1 -> 0).
REQ-015 Output register SHALL be one stage; x1.tvalid = x2.tvalid = out_vld; latency from accepted PAIR beat to output valid = 1 cycle.
REQ-016 out_vld SHALL clear when both treadies are high and no new PAIR beat is accepted that cycle; data/tlast/tuser hold stable while valid and not accepted.
REQ-017 Output transfer occurs only when x1.tready && x2.tready; the block never presents x1 without x2.
REQ-018 x1.tlast = x2.tlast = 1 only on the pair for idx = H-1; x1.tuser = x2.tuser = fc value of the frame being emitted.
REQ-019 FILL beats and PAIR beats in the same frame SHALL not require any gap; full throughput is 1 beat/cycle with treadies high.
REQ-020 Early tlast (accepted beat with tlast = 1 at any position other than PAIR idx = H-1): err pulses next cycle, beat discarded (no output), FSM -> FILL, idx = 0, fc unchanged.
REQ-021 Missing tlast (PAIR idx = H-1 accepted with tlast = 0): pair is still emitted with tlast = 1, err pulses next cycle, FSM -> FILL, fc increments.
REQ-022 A pending output not yet accepted SHALL be preserved across an early-tlast resync.
REQ-023 Simultaneous output acceptance and new PAIR beat in one cycle SHALL reload the output register with no bubble.

Reset
REQ-024 On rst asserted: FSM = FILL, idx = 0, fc = 0, out_vld = 0, x1/x2 tdata = 0, tlast = 0, tuser = 0, err = 0, s_axis.tready = 0 while rst high.
REQ-025 Reset mid-frame SHALL discard the partial frame and any unaccepted output; first beat after release is treated as frame beat 0.

Verification
REQ-026 FFT_LEN = 16, treadies = 1, beats i = 0..15 with re = i, im = -i, tlast on 15 -> 8 pairs (x1, x2) = (0,8)..(7,15) with im negated, first valid 1 cycle after beat 8, tlast on pair 7, tuser = 0, err never high.
REQ-027 Same stimulus, treadies toggled 1,0,0,1,... -> s_axis.tready low in PAIR while output stalled; all 8 pairs emitted in order, none duplicated or dropped; held data stable during stall; FILL beats unaffected.
REQ-028 Two back-to-back frames, no gaps -> 16 pairs, tuser 0 then 1, beat 0 of frame 2 accepted the cycle after beat 15 of frame 1.
REQ-029 tlast asserted on beat 5 of frame -> err single-cycle pulse, zero outputs; following clean frame pairs (0,8)..(7,15) correctly with tuser 0.
REQ-030 tlast omitted on beat 15 -> pair (7,15) emitted with tlast = 1, err pulse, fc = 1; next frame emits with tuser 1.
REQ-031 rst pulsed after beat 11 accepted -> all outputs 0, tvalid 0 in reset; subsequent full frame yields pairs (0,8)..(7,15), tuser 0.
